io_arbiter: RTL and testbench
=============================

IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the IO address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the IO data width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 m0_req/m1_req  in  1  SHALL be master access requests (m0 = CPU, m1 = SDU debug).
REQ-006 m0_we/m1_we  in  1  SHALL select the access type: 1 = write, 0 = read.
REQ-007 m0_addr/m1_addr  in  ADDR_W  SHALL be the master addresses.
REQ-008 m0_wdata/m1_wdata  in  DATA_W  SHALL be the master write data.
REQ-009 m0_ack/m1_ack  out  1  SHALL each pulse for one cycle when that master's transaction completes.
REQ-010 m0_rdata/m1_rdata  out  DATA_W  SHALL carry read data, valid while the matching ack is high.
REQ-011 io_addr  out  ADDR_W, io_dout  out  DATA_W, io_we  out  1, io_rd  out  1 SHALL form the slave-side IO bus.
REQ-012 io_din  in  DATA_W  SHALL be the slave read data, combinational from io_addr/io_rd.
REQ-013 cnt_m0/cnt_m1  out  32  SHALL count completed transactions per master.

Function
REQ-014 The FSM SHALL have three states, IDLE, ACCESS and RESP, with IDLE as the reset state.
REQ-015 In IDLE with any request high, the FSM SHALL latch the winner index plus its we/addr/wdata and move to ACCESS.
REQ-016 In IDLE with no request high, the FSM SHALL stay in IDLE.
REQ-017 In ACCESS, the latched addr/wdata SHALL be driven on io_addr/io_dout, with io_we = latched we and io_rd = ~latched we, for exactly one cycle.
REQ-018 At the end of an ACCESS read, the FSM SHALL register io_din into the winner's rdata.
REQ-019 ACCESS SHALL always move to RESP.
REQ-020 In RESP, the FSM SHALL assert only the winner's ack for one cycle, hold its rdata, and return to IDLE.
REQ-021 Outside ACCESS, io_we, io_rd, io_addr and io_dout SHALL be 0.
REQ-022 Latency SHALL be: req sampled high in IDLE at cycle N gives io strobe in N+1 and ack in N+2; the next grant is no earlier than N+3.
REQ-023 Arbitration SHALL be round-robin: on simultaneous requests, the master not granted last wins.
REQ-024 After reset, the round-robin pointer SHALL favour m0.
REQ-025 With a single requester, that requester SHALL win regardless of the pointer.
REQ-026 Masters SHALL hold req/we/addr/wdata until ack; the arbiter uses only values latched in IDLE, so changes after the grant are ignored.
REQ-027 A request still high in the cycle after its ack SHALL be treated as a new transaction.
REQ-028 The non-granted master's req SHALL remain pending, with no ack and no loss.
REQ-029 The counter of the acked master SHALL increment by 1 in the ack cycle and wrap modulo 2^32.
REQ-030 At most one ack SHALL be high in any cycle, and at most one of io_we/io_rd.
REQ-031 rdata for write transactions SHALL be 0.

Reset
REQ-032 When rst is high, the FSM SHALL go to IDLE and the pointer SHALL favour m0.
REQ-033 When rst is high, acks, io strobes, io_addr, io_dout, rdata, cnt_m0 and cnt_m1 SHALL all be 0 at the next edge.
REQ-034 Reset asserted during ACCESS or RESP SHALL abort the transaction with no ack and no counter increment.

Structure
REQ-035 A shared package SHALL hold the FSM state enumeration and the default ADDR_W/DATA_W constants.
REQ-036 Winner selection SHALL be a sub-module rr_arb2: inputs req[1:0], last; output grant index; purely combinational.
REQ-037 The FSM, latches and counters SHALL reside in io_arbiter.

Verification
REQ-038 m0 write addr 0x04 data 0x1234 -> io_we=1, io_addr=0x04, io_dout=0x1234 in cycle N+1; m0_ack in N+2; cnt_m0=1.
REQ-039 m1 read addr 0x10 with io_din=0xDEADBEEF -> io_rd=1 in N+1; m1_ack with m1_rdata=0xDEADBEEF in N+2; m0_ack stays 0.
REQ-040 Both masters request continuously from reset for 4 transactions -> grant order m0,m1,m0,m1; cnt_m0=cnt_m1=2.
REQ-041 m0 changes addr from 0x04 to 0x08 in the ACCESS cycle -> io_addr stays 0x04.
REQ-042 rst pulsed during ACCESS of an m1 read -> no m1_ack, cnt_m1 unchanged, io_rd=0 the next cycle, next simultaneous request grants m0.
REQ-043 cnt_m0 preloaded via force to 0xFFFFFFFF, then one m0 transaction -> cnt_m0=0.

Source files
------------

// File: rtl/io_arbiter_pkg.sv
// Shared definitions for the two-master IO arbiter.
// Holds the arbiter FSM state encoding and the default bus widths.
// No logic lives here; it is imported by io_arbiter.
package io_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/io_arbiter_rr_arb2.sv
// Two-way round-robin winner select, purely combinational.
// Ports: req[1:0] request vector, last = index granted most recently,
//        grant = winning index (0 when nothing is requested).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      // Contention: the master that did not win last time goes first.
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/io_arbiter.sv
// Arbitrates a CPU master (m0) and a debug master (m1) onto one IO bus.
// Ports: m*_req/we/addr/wdata in, m*_ack/rdata out, io_* slave bus,
//        cnt_m0/cnt_m1 completed-transaction counters.
// Latency: grant in IDLE, one ACCESS strobe cycle, one RESP ack cycle.
module io_arbiter
  import io_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_dout,
  output logic              io_we,
  output logic              io_rd,
  input  logic [DATA_W-1:0] io_din,
  output logic [31:0]       cnt_m0,
  output logic [31:0]       cnt_m1
);

  state_t              state_q, state_d;
  logic                win_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                last_q;
  logic                grant;
  logic                any_req;

  assign any_req = m0_req | m1_req;

  rr_arb2 u_rr_arb2 (
    .req   ({m1_req, m0_req}),
    .last  (last_q),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    io_we   = 1'b0;
    io_rd   = 1'b0;
    io_addr = '0;
    io_dout = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        io_we   = we_q;
        io_rd   = ~we_q;
        io_addr = addr_q;
        io_dout = wdata_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        m0_ack  = ~win_q;
        m1_ack  = win_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction capture: only the values seen at grant time are used, so
  // a master wiggling its bus after the grant cannot disturb the access.
  // last_q resets to 1 so that the first contention goes to m0.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b1;
    end else if (state_q == ST_IDLE && any_req) begin
      win_q   <= grant;
      last_q  <= grant;
      we_q    <= grant ? m1_we    : m0_we;
      addr_q  <= grant ? m1_addr  : m0_addr;
      wdata_q <= grant ? m1_wdata : m0_wdata;
    end
  end

  // Read data is captured at the end of ACCESS and held afterwards;
  // writes clear the winner's rdata so stale read data is never presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state_q == ST_ACCESS) begin
      if (win_q) m1_rdata <= we_q ? '0 : io_din;
      else       m0_rdata <= we_q ? '0 : io_din;
    end
  end

  // Counters step on the ack cycle; reset has priority so an aborted
  // transaction is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_m0 <= '0;
      cnt_m1 <= '0;
    end else if (state_q == ST_RESP) begin
      if (win_q) cnt_m1 <= cnt_m1 + 32'd1;
      else       cnt_m0 <= cnt_m0 + 32'd1;
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// Directed self-checking bench for io_arbiter.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// io_din is a small combinational slave model keyed on io_addr.
module tb_io_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [7:0]  io_addr;
  logic [31:0] io_dout, io_din;
  logic        io_we, io_rd;
  logic [31:0] cnt_m0, cnt_m1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb io_din = (io_addr == 8'h10) ? 32'hDEADBEEF : {16'hC0DE, 8'h00, io_addr};

  io_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd),
    .io_din(io_din), .cnt_m0(cnt_m0), .cnt_m1(cnt_m1)
  );

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  // Leaves rst low right after a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL reset_m0_ack got %b want 0", m0_ack); end
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL reset_m1_ack got %b want 0", m1_ack); end
    checks++; if ({io_we, io_rd} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {io_we, io_rd}); end
    checks++; if (io_addr !== 8'h0) begin errors++; $display("FAIL reset_io_addr got %h want 00", io_addr); end
    checks++; if (io_dout !== 32'h0) begin errors++; $display("FAIL reset_io_dout got %h want 0", io_dout); end
    checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", m0_rdata, m1_rdata); end
    checks++; if (cnt_m0 !== 32'h0 || cnt_m1 !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h/%h want 0/0", cnt_m0, cnt_m1); end
    rst = 0;
  endtask

  task automatic test_write();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 8'h04; m0_wdata = 32'h1234;
    @(negedge clk);  // ACCESS
    checks++; if (io_we !== 1'b1 || io_rd !== 1'b0) begin errors++; $display("FAIL wr_strobe got we=%b rd=%b want 1/0", io_we, io_rd); end
    checks++; if (io_addr !== 8'h04) begin errors++; $display("FAIL wr_addr got %h want 04", io_addr); end
    checks++; if (io_dout !== 32'h1234) begin errors++; $display("FAIL wr_dout got %h want 1234", io_dout); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL wr_early_ack got %b want 0", m0_ack); end
    @(negedge clk);  // RESP
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL wr_ack got %b%b want 10", m0_ack, m1_ack); end
    checks++; if (io_we !== 1'b0 || io_addr !== 8'h0 || io_dout !== 32'h0) begin errors++; $display("FAIL wr_bus_idle got we=%b addr=%h dout=%h want 0", io_we, io_addr, io_dout); end
    m0_req = 0;
    @(negedge clk);
    checks++; if (cnt_m0 !== 32'd1) begin errors++; $display("FAIL wr_cnt got %0d want 1", cnt_m0); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b want 0", m0_ack); end
  endtask

  task automatic test_read();
    do_reset();
    idle_inputs();
    m1_req = 1; m1_we = 0; m1_addr = 8'h10;
    @(negedge clk);
    checks++; if (io_rd !== 1'b1 || io_we !== 1'b0) begin errors++; $display("FAIL rd_strobe got rd=%b we=%b want 1/0", io_rd, io_we); end
    checks++; if (io_addr !== 8'h10) begin errors++; $display("FAIL rd_addr got %h want 10", io_addr); end
    @(negedge clk);
    checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL rd_ack got m0=%b m1=%b want 0/1", m0_ack, m1_ack); end
    checks++; if (m1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", m1_rdata); end
    m1_req = 0;
    @(negedge clk);
    checks++; if (cnt_m1 !== 32'd1 || cnt_m0 !== 32'd0) begin errors++; $display("FAIL rd_cnt got %0d/%0d want 0/1", cnt_m0, cnt_m1); end
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    m0_req = 1; m0_addr = 8'h20;
    m1_req = 1; m1_addr = 8'h30;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if (m0_ack !== (k == 2 || k == 8) || m1_ack !== (k == 5 || k == 11)) begin
        errors++; $display("FAIL rr_ack_k%0d got m0=%b m1=%b", k, m0_ack, m1_ack);
      end
      checks++; if (io_we & io_rd) begin errors++; $display("FAIL rr_strobe_excl_k%0d got we=1 rd=1 want at most one", k); end
      if (k == 2) begin
        checks++; if (m0_rdata !== 32'hC0DE0020) begin errors++; $display("FAIL rr_m0_rdata got %h want c0de0020", m0_rdata); end
      end
      if (k == 5) begin
        checks++; if (m1_rdata !== 32'hC0DE0030) begin errors++; $display("FAIL rr_m1_rdata got %h want c0de0030", m1_rdata); end
      end
      if (k == 11) begin m0_req = 0; m1_req = 0; end
    end
    @(negedge clk);
    checks++; if (cnt_m0 !== 32'd2 || cnt_m1 !== 32'd2) begin errors++; $display("FAIL rr_cnt got %0d/%0d want 2/2", cnt_m0, cnt_m1); end
  endtask

  task automatic test_addr_hold();
    do_reset();
    idle_inputs();
    m0_req = 1; m0_we = 1; m0_addr = 8'h04; m0_wdata = 32'h55;
    @(negedge clk);  // ACCESS
    m0_addr = 8'h08; m0_wdata = 32'h99;
    #1;
    checks++; if (io_addr !== 8'h04) begin errors++; $display("FAIL hold_addr got %h want 04", io_addr); end
    checks++; if (io_dout !== 32'h55) begin errors++; $display("FAIL hold_dout got %h want 55", io_dout); end
    @(negedge clk);
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL hold_ack got %b want 1", m0_ack); end
    m0_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    do_reset();
    idle_inputs();
    m1_req = 1; m1_we = 0; m1_addr = 8'h10;
    @(negedge clk);  // ACCESS of m1 read
    checks++; if (io_rd !== 1'b1) begin errors++; $display("FAIL abort_pre_rd got %b want 1", io_rd); end
    rst = 1;
    @(negedge clk);
    checks++; if (io_rd !== 1'b0) begin errors++; $display("FAIL abort_io_rd got %b want 0", io_rd); end
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL abort_m1_ack got %b want 0", m1_ack); end
    checks++; if (cnt_m1 !== 32'd0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL abort_state got cnt=%0d rdata=%h want 0/0", cnt_m1, m1_rdata); end
    rst = 0;
    m0_req = 1; m0_we = 1; m0_addr = 8'h44; m0_wdata = 32'h77;
    @(negedge clk);
    checks++; if (io_we !== 1'b1 || io_addr !== 8'h44) begin errors++; $display("FAIL abort_regrant got we=%b addr=%h want 1/44", io_we, io_addr); end
    @(negedge clk);
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL abort_m0_ack got %b%b want 10", m0_ack, m1_ack); end
    m0_req = 0;
    @(negedge clk);  // IDLE, m1 still pending
    @(negedge clk);
    checks++; if (io_rd !== 1'b1 || io_addr !== 8'h10) begin errors++; $display("FAIL pending_m1_access got rd=%b addr=%h want 1/10", io_rd, io_addr); end
    @(negedge clk);
    checks++; if (m1_ack !== 1'b1 || m1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL pending_m1_ack got ack=%b data=%h want 1/deadbeef", m1_ack, m1_rdata); end
    m1_req = 0;
    @(negedge clk);
    checks++; if (cnt_m0 !== 32'd1 || cnt_m1 !== 32'd1) begin errors++; $display("FAIL abort_cnt got %0d/%0d want 1/1", cnt_m0, cnt_m1); end
  endtask

  task automatic test_ptr_reset();
    do_reset();
    idle_inputs();
    m0_req = 1; m0_we = 1; m0_addr = 8'h01;
    @(negedge clk);
    @(negedge clk);
    m0_req = 0;
    @(negedge clk);  // pointer now favours m1
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 8'h02;
    m1_req = 1; m1_we = 1; m1_addr = 8'h03;
    @(negedge clk);
    checks++; if (io_addr !== 8'h02) begin errors++; $display("FAIL ptr_reset_grant got %h want 02", io_addr); end
    @(negedge clk);
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL ptr_reset_ack got %b want 1", m0_ack); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    idle_inputs();
    m0_req = 1; m0_we = 0; m0_addr = 8'h05;
    @(negedge clk);  // ACCESS read
    @(negedge clk);  // RESP
    checks++; if (m0_ack !== 1'b1 || m0_rdata !== 32'hC0DE0005) begin errors++; $display("FAIL b2b_first got ack=%b data=%h want 1/c0de0005", m0_ack, m0_rdata); end
    m0_we = 1; m0_wdata = 32'hAB;
    @(negedge clk);  // IDLE, req still high
    checks++; if (m0_ack !== 1'b0 || io_we !== 1'b0) begin errors++; $display("FAIL b2b_gap got ack=%b we=%b want 0/0", m0_ack, io_we); end
    @(negedge clk);
    checks++; if (io_we !== 1'b1 || io_dout !== 32'hAB) begin errors++; $display("FAIL b2b_second_access got we=%b dout=%h want 1/ab", io_we, io_dout); end
    @(negedge clk);
    checks++; if (m0_ack !== 1'b1 || m0_rdata !== 32'h0) begin errors++; $display("FAIL b2b_write_rdata got ack=%b data=%h want 1/0", m0_ack, m0_rdata); end
    m0_req = 0;
    @(negedge clk);
    checks++; if (cnt_m0 !== 32'd2) begin errors++; $display("FAIL b2b_cnt got %0d want 2", cnt_m0); end
  endtask

  task automatic test_wrap();
    do_reset();
    idle_inputs();
    force dut.cnt_m0 = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cnt_m0;
    m0_req = 1; m0_we = 1; m0_addr = 8'h07;
    @(negedge clk);
    @(negedge clk);
    m0_req = 0;
    @(negedge clk);
    checks++; if (cnt_m0 !== 32'h0) begin errors++; $display("FAIL wrap_cnt_m0 got %h want 0", cnt_m0); end
    checks++; if (cnt_m1 !== 32'h0) begin errors++; $display("FAIL wrap_cnt_m1 got %h want 0", cnt_m1); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_addr_hold();
    test_reset_abort();
    test_ptr_reset();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
